// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: steps RV32I instructions through FETCH/DECODE/EXEC/MEM/WB over a shared req/ready memory port.
module multicycle_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_is_fetch,
    output logic             ir_load,
    output logic             reg_write_en,
    output logic             pc_write,
    output logic             instr_done,
    output logic [2:0]       state,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] retired
);
    localparam int WW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WW-1:0] LAST = WW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
    typedef enum logic [2:0] {IDLE = 3'd0, FETCH, DECODE, EXEC, MEM, WB, ERR} state_t;
    typedef enum logic [2:0] {C_NONE, C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_ILL} cls_t;
    state_t        st;
    cls_t          cls;
    cls_t          dec;
    logic [WW-1:0] wait_cnt;
    logic          timeout;
    logic          retire;
    always_comb begin
        case (opcode)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: dec = C_ALU;
            7'b0000011: dec = C_LOAD;
            7'b0100011: dec = C_STORE;
            7'b1100011: dec = C_BRANCH;
            7'b1101111, 7'b1100111: dec = C_JUMP;
            default: dec = C_ILL;
        endcase
    end
    assign timeout = (TIMEOUT_CYCLES != 0) && !mem_ready && wait_cnt == LAST;
    // A store retires on the MEM cycle that completes, so its pulses must wait for mem_ready.
    assign retire = st == WB || (st == EXEC && cls == C_BRANCH) || (st == MEM && cls == C_STORE && mem_ready);
    assign state = st;
    assign mem_req = st == FETCH || st == MEM;
    assign mem_is_fetch = st == FETCH;
    assign mem_we = st == MEM && cls == C_STORE;
    assign ir_load = st == FETCH && mem_ready;
    assign reg_write_en = st == WB;
    assign pc_write = retire;
    assign instr_done = retire;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
            cls <= C_NONE;
            err_code <= '0;
            retired <= '0;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= (st == FETCH || st == MEM) && !mem_ready ? wait_cnt + WW'(1) : '0;
            if (retire)
                retired <= retired + CNT_W'(1);
            case (st)
                IDLE: if (run) st <= FETCH;
                FETCH: begin
                    if (mem_ready) st <= DECODE;
                    else if (timeout) begin
                        st <= ERR;
                        err_code <= 2'b10;
                    end
                end
                DECODE: begin
                    cls <= dec;
                    if (dec == C_ILL) begin
                        st <= ERR;
                        err_code <= 2'b01;
                    end else st <= EXEC;
                end
                EXEC: st <= cls == C_BRANCH ? (run ? FETCH : IDLE) : (cls == C_LOAD || cls == C_STORE) ? MEM : WB;
                MEM: begin
                    if (mem_ready) st <= cls == C_LOAD ? WB : run ? FETCH : IDLE;
                    else if (timeout) begin
                        st <= ERR;
                        err_code <= 2'b10;
                    end
                end
                WB: st <= run ? FETCH : IDLE;
                default: st <= ERR;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed and randomized instruction traces checked against a per-instruction cycle model.
module tb_multicycle_sequencer;
    localparam int CW = 4;
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_ERR = 3'd6;
    localparam logic [6:0] OP_ALU = 7'b0110011, OP_LD = 7'b0000011, OP_ST = 7'b0100011,
                           OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
    logic clk = 1'b0, rst_n, run, mem_ready;
    logic [6:0] opcode;
    logic mem_req, mem_we, mem_is_fetch, ir_load, reg_write_en, pc_write, instr_done;
    logic [2:0] state;
    logic [1:0] err_code;
    logic [CW-1:0] retired;
    int n_tests = 0, n_fail = 0, m_ret = 0;
    logic m_idle = 1'b1;
    logic [6:0] legal [9] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR};

    multicycle_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_is_fetch(mem_is_fetch), .ir_load(ir_load),
        .reg_write_en(reg_write_en), .pc_write(pc_write), .instr_done(instr_done),
        .state(state), .err_code(err_code), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] ro();
        return 7'($urandom);
    endfunction

    function automatic logic [9:0] obs();
        return {state, mem_req, mem_we, mem_is_fetch, ir_load, reg_write_en, pc_write, instr_done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance past the edge.
    task automatic cyc(input logic rdy, input logic [6:0] op, input logic r, input logic [9:0] e, input string tag);
        mem_ready = rdy;
        opcode = op;
        run = r;
        @(negedge clk);
        chk(tag, 32'(obs()), 32'(e));
        @(posedge clk);
        #1;
    endtask

    // Expected trace of one legal instruction from the latency rules of each class.
    task automatic instr(input logic [6:0] op, input int fw, input int mw, input logic re);
        bit is_ld = op == OP_LD, is_st = op == OP_ST, is_br = op == OP_BR;
        if (m_idle) cyc(rb(), ro(), 1'b1, {S_IDLE, 7'b0}, "idle");
        for (int i = 0; i < fw; i++) cyc(1'b0, ro(), rb(), {S_FETCH, 7'b1010000}, "fetch_wait");
        cyc(1'b1, ro(), rb(), {S_FETCH, 7'b1011000}, "fetch_done");
        cyc(rb(), op, rb(), {S_DECODE, 7'b0}, "decode");
        if (is_br) begin
            cyc(rb(), ro(), re, {S_EXEC, 7'b0000011}, "exec_branch");
            m_ret++;
        end else cyc(rb(), ro(), rb(), {S_EXEC, 7'b0}, "exec");
        if (is_ld || is_st) begin
            for (int i = 0; i < mw; i++) cyc(1'b0, ro(), rb(), {S_MEM, is_st ? 7'b1100000 : 7'b1000000}, "mem_wait");
            if (is_st) begin
                cyc(1'b1, ro(), re, {S_MEM, 7'b1100011}, "mem_store");
                m_ret++;
            end else cyc(1'b1, ro(), rb(), {S_MEM, 7'b1000000}, "mem_load");
        end
        if (!is_br && !is_st) begin
            cyc(rb(), ro(), re, {S_WB, 7'b0000111}, "wb");
            m_ret++;
        end
        m_idle = !re;
        chk("retired", 32'(retired), 32'(m_ret & 15));
        chk("err_none", 32'(err_code), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        chk("reset_outs", 32'(obs()), 0);
        chk("reset_err", 32'(err_code), 0);
        chk("reset_retired", 32'(retired), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_idle = 1'b1;
        m_ret = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        run = 1'b0;
        mem_ready = 1'b0;
        opcode = '0;
        #2;
        do_reset();
        instr(OP_ALU, 0, 0, 1'b1);
        instr(OP_LD, 0, 3, 1'b1);
        instr(OP_ST, 0, 0, 1'b1);
        instr(OP_BR, 0, 0, 1'b0);
        for (int k = 0; k < 40; k++)
            instr(legal[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) != 0);
        instr(OP_LD, 0, 15, 1'b1);
        instr(OP_JALR, 15, 0, 1'b0);
        // Illegal opcode: sticky ERR, run ignored, cleared only by reset.
        cyc(rb(), ro(), 1'b1, {S_IDLE, 7'b0}, "idle_ill");
        cyc(1'b1, ro(), rb(), {S_FETCH, 7'b1011000}, "fetch_ill");
        cyc(rb(), 7'b1111111, rb(), {S_DECODE, 7'b0}, "decode_ill");
        for (int i = 0; i < 4; i++) begin
            cyc(rb(), ro(), 1'(i), {S_ERR, 7'b0}, "err_ill");
            chk("err_code_ill", 32'(err_code), 1);
        end
        do_reset();
        // Fetch timeout after 16 waiting cycles.
        cyc(rb(), ro(), 1'b1, {S_IDLE, 7'b0}, "idle_to");
        for (int i = 0; i < 16; i++) cyc(1'b0, ro(), rb(), {S_FETCH, 7'b1010000}, "fetch_to");
        for (int i = 0; i < 3; i++) begin
            cyc(rb(), ro(), rb(), {S_ERR, 7'b0}, "err_fetch_to");
            chk("err_code_fetch_to", 32'(err_code), 2);
        end
        do_reset();
        // Store timeout in MEM.
        cyc(rb(), ro(), 1'b1, {S_IDLE, 7'b0}, "idle_mto");
        cyc(1'b1, ro(), rb(), {S_FETCH, 7'b1011000}, "fetch_mto");
        cyc(rb(), OP_ST, rb(), {S_DECODE, 7'b0}, "decode_mto");
        cyc(rb(), ro(), rb(), {S_EXEC, 7'b0}, "exec_mto");
        for (int i = 0; i < 16; i++) cyc(1'b0, ro(), rb(), {S_MEM, 7'b1100000}, "mem_to");
        cyc(rb(), ro(), rb(), {S_ERR, 7'b0}, "err_mem_to");
        chk("err_code_mem_to", 32'(err_code), 2);
        chk("retired_mem_to", 32'(retired), 0);
        do_reset();
        // Counter wrap.
        for (int i = 0; i < 15; i++) instr(OP_BR, 0, 0, 1'b1);
        chk("retired_ones", 32'(retired), 15);
        instr(OP_BR, 0, 0, 1'b0);
        chk("retired_wrap", 32'(retired), 0);
        // Reset asserted while a load waits in MEM.
        cyc(rb(), ro(), 1'b1, {S_IDLE, 7'b0}, "idle_rm");
        cyc(1'b1, ro(), rb(), {S_FETCH, 7'b1011000}, "fetch_rm");
        cyc(rb(), OP_LD, rb(), {S_DECODE, 7'b0}, "decode_rm");
        cyc(rb(), ro(), rb(), {S_EXEC, 7'b0}, "exec_rm");
        cyc(1'b0, ro(), 1'b1, {S_MEM, 7'b1000000}, "mem_rm");
        #2;
        do_reset();
        instr(OP_JAL, 1, 0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
